// File: rtl/wide_add_seq_pkg.sv
// rtl/wide_add_seq_pkg.sv - shared slice width and FSM state encoding for wide_add_seq
package wide_add_seq_pkg;

    localparam int SLICE_W   = 16;
    localparam int SLICE_LOG = $clog2(SLICE_W);

    // Encoding 2'd3 is unused; the FSM recovers from it to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wide_add_seq_if.sv
// rtl/wide_add_seq_if.sv - request/result handshake bundle for wide_add_seq
interface wide_add_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/wide_add_seq_adder16.sv
// rtl/wide_add_seq_adder16.sv - 16-bit carry-lookahead adder slice (4x4-bit groups)
module wide_add_seq_adder16
    import wide_add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] in1,
    input  logic [SLICE_W-1:0] in2,
    input  logic               c0,
    output logic [SLICE_W-1:0] sout,
    output logic               cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  cb;
    logic        cc;

    always_comb begin
        g  = in1 & in2;
        p  = in1 ^ in2;
        gg = '0;
        gp = '0;
        cb = '0;
        c  = '0;
        cc = 1'b0;
        cb[0] = c0;
        // Group carries come from lookahead; only bits inside a group ripple.
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            cb[k+1] = gg[k] | (gp[k] & cb[k]);
        end
        for (int k = 0; k < 4; k++) begin
            cc = cb[k];
            for (int j = 0; j < 4; j++) begin
                c[4*k+j] = cc;
                cc = g[4*k+j] | (p[4*k+j] & cc);
            end
        end
        sout = p ^ c;
        cout = cb[4];
    end
endmodule

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - sequential WIDTH-bit add/sub, one 16-bit slice per cycle, LSB first
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic          clk,
    input  logic          rst,
    wide_add_seq_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    state_t                 state;
    logic [WIDTH-1:0]       a_r;
    logic [WIDTH-1:0]       b_r;
    logic [WIDTH-1:0]       sum_r;
    logic [IW-1:0]          idx;
    logic                   carry;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic                   cout_r;
    logic                   ovf_r;
    logic [IW+SLICE_LOG-1:0] base;
    logic [SLICE_W-1:0]     a_s;
    logic [SLICE_W-1:0]     b_s;
    logic [SLICE_W-1:0]     sout;
    logic                   cout;

    assign base = {idx, {SLICE_LOG{1'b0}}};
    assign a_s  = a_r[base +: SLICE_W];
    assign b_s  = b_r[base +: SLICE_W];

    wide_add_seq_adder16 u_add (
        .in1  (a_s),
        .in2  (b_s),
        .c0   (carry),
        .sout (sout),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.in_a;
                        // Subtraction is A + ~B + 1: invert B here, carry-in 1.
                        b_r        <= bus.in_b ^ {WIDTH{bus.in_sub}};
                        carry      <= bus.in_sub;
                        idx        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    sum_r[base +: SLICE_W] <= sout;
                    carry <= cout;
                    idx   <= idx + IW'(1);
                    if (idx == LAST) begin
                        cout_r      <= cout;
                        // Sum MSB is still on the adder output this cycle.
                        ovf_r       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                       (sout[SLICE_W-1] != a_r[WIDTH-1]);
                        out_valid_r <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = sum_r;
    assign bus.out_cout  = cout_r;
    assign bus.out_ovf   = ovf_r;
endmodule
